// File: rtl/fft_frame_buffer_if.sv
// Sample stream bundle around the frame buffer: windowed input in, frame samples out to the FFT.
interface fft_frame_buffer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  data_in, data_valid, out_ready,
        output out_data, out_valid, out_last
    );

    modport slave (
        output data_in, data_valid, out_ready,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame assembler between the window stage and the FFT core: two banks collect
// FFT_SIZE-sample frames, completed frames stream out in natural or bit-reversed order.
module fft_frame_buffer #(
    parameter int WIDTH       = 32,
    parameter int FFT_SIZE    = 1024,
    parameter int BIT_REVERSE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_frame_buffer_if.master bus,
    output logic               overflow,
    output logic [15:0]        dropped_count
);
    localparam int            AW   = $clog2(FFT_SIZE);
    localparam logic [AW-1:0] LAST = AW'(FFT_SIZE - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_e;
    typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_st_e;

    bank_st_e          bank_q [2];
    bank_st_e          bank_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       cnt_q, cnt_d;
    rd_st_e            rd_state_q, rd_state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AW-1:0]     k_q, k_d;

    logic [WIDTH-1:0]  mem [2*FFT_SIZE];
    logic [WIDTH-1:0]  ram_q;
    logic              wen, ren;
    logic [AW-1:0]     raddr_idx;
    logic              hs, rd_done, other, full0, full1, pick;

    function automatic logic [AW-1:0] idx_map(input logic [AW-1:0] i);
        idx_map = i;
        if (BIT_REVERSE != 0)
            for (int b = 0; b < AW; b++) idx_map[b] = i[AW-1-b];
    endfunction

    assign hs      = (rd_state_q == RD_STREAM) && bus.out_ready;
    assign rd_done = hs && (k_q == LAST);
    assign other   = ~wr_bank_q;
    assign full0   = (bank_q[0] == B_FULL);
    assign full1   = (bank_q[1] == B_FULL);
    // Both full only happens while the writer is dropping, parked on the newer bank.
    assign pick    = (full0 && full1) ? ~wr_bank_q : full1;

    // Read FSM: the RAM output register only advances on a handshake, so it doubles as the
    // hold register while the FFT stalls.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        k_d        = k_q;
        ren        = 1'b0;
        raddr_idx  = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (full0 || full1) begin
                    rd_bank_d  = pick;
                    rd_state_d = RD_PRIME;
                end
            end
            RD_PRIME: begin
                ren        = 1'b1;
                k_d        = '0;
                rd_state_d = RD_STREAM;
            end
            RD_STREAM: begin
                if (hs) begin
                    if (k_q == LAST) begin
                        rd_state_d = RD_IDLE;
                    end else begin
                        k_d       = k_q + 1'b1;
                        ren       = 1'b1;
                        raddr_idx = idx_map(k_q + 1'b1);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write side and bank bookkeeping.
    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        drop_d    = drop_q;
        ovf_d     = 1'b0;
        cnt_d     = cnt_q;
        wen       = 1'b0;
        if (rd_done) bank_d[rd_bank_q] = B_EMPTY;
        if (drop_q) begin
            if (bus.data_valid) begin
                ovf_d = 1'b1;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
            if (rd_done) begin
                drop_d    = 1'b0;
                wr_bank_d = rd_bank_q;
                wr_ptr_d  = '0;
            end
        end else if (bus.data_valid) begin
            wen = 1'b1;
            if (wr_ptr_q == LAST) begin
                bank_d[wr_bank_q] = B_FULL;
                wr_ptr_d          = '0;
                // A bank freed on this same edge counts as available.
                if (bank_q[other] == B_EMPTY || (rd_done && rd_bank_q == other))
                    wr_bank_d = other;
                else
                    drop_d = 1'b1;
            end else begin
                bank_d[wr_bank_q] = B_FILLING;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            k_q        <= '0;
        end else begin
            bank_q     <= bank_d;
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            k_q        <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wen) mem[{wr_bank_q, wr_ptr_q}] <= bus.data_in;
        if (ren) ram_q <= mem[{rd_bank_q, raddr_idx}];
    end

    assign bus.out_valid  = (rd_state_q == RD_STREAM);
    assign bus.out_last   = (rd_state_q == RD_STREAM) && (k_q == LAST);
    assign bus.out_data   = (rd_state_q == RD_STREAM) ? ram_q : '0;
    assign overflow       = ovf_q;
    assign dropped_count  = cnt_q;
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench: two buffers (bit-reversed and natural order) share one stimulus stream.
module tb_fft_frame_buffer;
    localparam int W = 16;
    localparam int N = 8;
    localparam int BR8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] din;
    logic         dv, rdy;
    logic         ovf_b, ovf_n;
    logic [15:0]  dc_b, dc_n;

    fft_frame_buffer_if #(.WIDTH(W)) ifb ();
    fft_frame_buffer_if #(.WIDTH(W)) ifn ();
    assign ifb.data_in = din;  assign ifb.data_valid = dv;  assign ifb.out_ready = rdy;
    assign ifn.data_in = din;  assign ifn.data_valid = dv;  assign ifn.out_ready = rdy;

    fft_frame_buffer #(.WIDTH(W), .FFT_SIZE(N), .BIT_REVERSE(1)) dut_br (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .overflow(ovf_b), .dropped_count(dc_b));
    fft_frame_buffer #(.WIDTH(W), .FFT_SIZE(N), .BIT_REVERSE(0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .bus(ifn), .overflow(ovf_n), .dropped_count(dc_n));

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collects accepted samples and stall-stability violations, sampled mid-cycle.
    logic [W-1:0] qb[$], qn[$];
    bit           lb[$], ln[$];
    int           cb[$];
    int           ovf_cnt_b, ovf_cnt_n, viol, wr_edge;
    logic         st_b, st_n, hl_b, hl_n;
    logic [W-1:0] hd_b, hd_n;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv) wr_edge = cyc + 1;
            if (ifb.out_valid && rdy) begin
                qb.push_back(ifb.out_data); lb.push_back(ifb.out_last); cb.push_back(cyc);
            end
            if (ifn.out_valid && rdy) begin
                qn.push_back(ifn.out_data); ln.push_back(ifn.out_last);
            end
            if (ovf_b) ovf_cnt_b++;
            if (ovf_n) ovf_cnt_n++;
            if (st_b && (ifb.out_valid !== 1'b1 || ifb.out_data !== hd_b || ifb.out_last !== hl_b)) viol++;
            if (st_n && (ifn.out_valid !== 1'b1 || ifn.out_data !== hd_n || ifn.out_last !== hl_n)) viol++;
            st_b = ifb.out_valid && !rdy; hd_b = ifb.out_data; hl_b = ifb.out_last;
            st_n = ifn.out_valid && !rdy; hd_n = ifn.out_data; hl_n = ifn.out_last;
        end else begin
            st_b = 1'b0;
            st_n = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        qb.delete(); qn.delete(); lb.delete(); ln.delete(); cb.delete();
        ovf_cnt_b = 0; ovf_cnt_n = 0; viol = 0; wr_edge = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dv = 1'b0; rdy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_mon();
    endtask

    // One ramp frame base..base+7, with 'gap' idle cycles after every sample.
    task automatic send(input int base, input int gap);
        for (int i = 0; i < N; i++) begin
            din = W'(base + i); dv = 1'b1;
            tick();
            dv = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dv = 1'b0; rdy = 1'b0; din = '0;
        repeat (2) tick();
        tests_run++;
        if ({ifb.out_valid, ifb.out_last, ovf_b, ifn.out_valid, ifn.out_last, ovf_n} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 000000",
                {ifb.out_valid, ifb.out_last, ovf_b, ifn.out_valid, ifn.out_last, ovf_n});
        end
        tests_run++;
        if (ifb.out_data !== '0 || ifn.out_data !== '0) begin
            fails++; $display("FAIL reset_data: got %h/%h want 0/0", ifb.out_data, ifn.out_data);
        end
        tests_run++;
        if (dc_b !== 16'd0 || dc_n !== 16'd0) begin
            fails++; $display("FAIL reset_dropped: got %0d/%0d want 0/0", dc_b, dc_n);
        end
        rst_n = 1'b1;
        clear_mon();
        repeat (3) tick();
        tests_run++;
        if (ifb.out_valid !== 1'b0 || ifn.out_valid !== 1'b0) begin
            fails++; $display("FAIL idle_valid: got %b/%b want 0/0", ifb.out_valid, ifn.out_valid);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        rdy = 1'b1;
        send(0, 0);
        repeat (16) tick();
        tests_run++;
        if (qb.size() != N || qn.size() != N) begin
            fails++; $display("FAIL single_count: got %0d/%0d want 8/8", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < N; i++) begin
                tests_run++;
                if (qb[i] !== W'(BR8[i]) || lb[i] !== (i == 7) || qn[i] !== W'(i) || ln[i] !== (i == 7)) begin
                    fails++;
                    $display("FAIL single_sample[%0d]: got br=%0d/%0b nat=%0d/%0b want br=%0d/%0b nat=%0d/%0b",
                             i, qb[i], lb[i], qn[i], ln[i], BR8[i], i == 7, i, i == 7);
                end
            end
            tests_run++;
            if (cb[0] != wr_edge + 2) begin
                fails++; $display("FAIL single_latency: first valid cycle %0d want %0d", cb[0], wr_edge + 2);
            end
            tests_run++;
            if (cb[N-1] - cb[0] != N - 1) begin
                fails++; $display("FAIL single_bubbles: span %0d want %0d", cb[N-1] - cb[0], N - 1);
            end
        end
        tests_run++;
        if (ovf_cnt_b != 0 || ovf_cnt_n != 0) begin
            fails++; $display("FAIL single_overflow: got %0d/%0d want 0/0", ovf_cnt_b, ovf_cnt_n);
        end
    endtask

    // Two idle cycles between input frames make the fill of frame 2 coincide with the
    // release of frame 1's bank.
    task automatic test_continuous();
        do_reset();
        rdy = 1'b1;
        send(0, 0);  repeat (2) tick();
        send(8, 0);  repeat (2) tick();
        send(16, 0);
        repeat (30) tick();
        tests_run++;
        if (qb.size() != 3*N || qn.size() != 3*N) begin
            fails++; $display("FAIL cont_count: got %0d/%0d want 24/24", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < 3*N; i++) begin
                tests_run++;
                if (qb[i] !== W'((i/8)*8 + BR8[i%8]) || qn[i] !== W'(i) ||
                    lb[i] !== (i%8 == 7) || ln[i] !== (i%8 == 7)) begin
                    fails++;
                    $display("FAIL cont_sample[%0d]: got br=%0d/%0b nat=%0d/%0b want br=%0d nat=%0d last=%0b",
                             i, qb[i], lb[i], qn[i], ln[i], (i/8)*8 + BR8[i%8], i, i%8 == 7);
                end
            end
            tests_run++;
            if (cb[8] - cb[7] != 3 || cb[16] - cb[15] != 3 || cb[7] - cb[0] != 7) begin
                fails++; $display("FAIL cont_gaps: got %0d,%0d,%0d want 3,3,7",
                                  cb[8] - cb[7], cb[16] - cb[15], cb[7] - cb[0]);
            end
        end
        tests_run++;
        if (dc_b !== 16'd0 || dc_n !== 16'd0) begin
            fails++; $display("FAIL cont_dropped: got %0d/%0d want 0/0", dc_b, dc_n);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        rdy = 1'b0;
        send(0, 0); send(8, 0); send(16, 0);
        repeat (4) tick();
        tests_run++;
        if (ovf_cnt_b != 8 || ovf_cnt_n != 8) begin
            fails++; $display("FAIL ovf_pulses: got %0d/%0d want 8/8", ovf_cnt_b, ovf_cnt_n);
        end
        tests_run++;
        if (dc_b !== 16'd8 || dc_n !== 16'd8) begin
            fails++; $display("FAIL ovf_dropped: got %0d/%0d want 8/8", dc_b, dc_n);
        end
        tests_run++;
        if (qb.size() != 0 || ifb.out_valid !== 1'b1 || viol != 0) begin
            fails++; $display("FAIL ovf_stall: got n=%0d valid=%b viol=%0d want 0/1/0",
                              qb.size(), ifb.out_valid, viol);
        end
        rdy = 1'b1;
        repeat (30) tick();
        tests_run++;
        if (qb.size() != 2*N || qn.size() != 2*N) begin
            fails++; $display("FAIL ovf_drain_count: got %0d/%0d want 16/16", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < 2*N; i++) begin
                tests_run++;
                if (qb[i] !== W'((i/8)*8 + BR8[i%8]) || qn[i] !== W'(i) || lb[i] !== (i%8 == 7)) begin
                    fails++; $display("FAIL ovf_drain[%0d]: got br=%0d nat=%0d last=%0b want br=%0d nat=%0d",
                                      i, qb[i], qn[i], lb[i], (i/8)*8 + BR8[i%8], i);
                end
            end
        end
        clear_mon();
        send(100, 0);
        repeat (16) tick();
        tests_run++;
        if (qb.size() != N || qn.size() != N) begin
            fails++; $display("FAIL ovf_refill_count: got %0d/%0d want 8/8", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < N; i++) begin
                tests_run++;
                if (qb[i] !== W'(100 + BR8[i]) || qn[i] !== W'(100 + i)) begin
                    fails++; $display("FAIL ovf_refill[%0d]: got %0d/%0d want %0d/%0d",
                                      i, qb[i], qn[i], 100 + BR8[i], 100 + i);
                end
            end
        end
        tests_run++;
        if (dc_b !== 16'd8 || ovf_cnt_b != 0) begin
            fails++; $display("FAIL ovf_refill_dropped: got %0d pulses=%0d want 8/0", dc_b, ovf_cnt_b);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fork
            send(0, 0);
            for (int c = 0; c < 60; c++) begin rdy = c[0]; tick(); end
        join
        fork
            send(32, 0);
            for (int c = 0; c < 100; c++) begin rdy = 1'($urandom_range(0, 1)); tick(); end
        join
        rdy = 1'b1;
        repeat (12) tick();
        tests_run++;
        if (qb.size() != 2*N || qn.size() != 2*N) begin
            fails++; $display("FAIL bp_count: got %0d/%0d want 16/16", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < 2*N; i++) begin
                tests_run++;
                if (qb[i] !== W'((i/8)*32 + BR8[i%8]) || qn[i] !== W'((i/8)*32 + i%8) ||
                    lb[i] !== (i%8 == 7) || ln[i] !== (i%8 == 7)) begin
                    fails++; $display("FAIL bp_sample[%0d]: got br=%0d/%0b nat=%0d/%0b want br=%0d nat=%0d last=%0b",
                                      i, qb[i], lb[i], qn[i], ln[i], (i/8)*32 + BR8[i%8], (i/8)*32 + i%8, i%8 == 7);
                end
            end
        end
        tests_run++;
        if (viol != 0 || dc_b !== 16'd0) begin
            fails++; $display("FAIL bp_stability: got viol=%0d dropped=%0d want 0/0", viol, dc_b);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        rdy = 1'b1;
        send(40, 2);
        repeat (16) tick();
        tests_run++;
        if (qb.size() != N || qn.size() != N) begin
            fails++; $display("FAIL gap_count: got %0d/%0d want 8/8", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < N; i++) begin
                tests_run++;
                if (qb[i] !== W'(40 + BR8[i]) || qn[i] !== W'(40 + i) || lb[i] !== (i == 7)) begin
                    fails++; $display("FAIL gap_sample[%0d]: got %0d/%0d last=%0b want %0d/%0d",
                                      i, qb[i], qn[i], lb[i], 40 + BR8[i], 40 + i);
                end
            end
            tests_run++;
            if (cb[0] != wr_edge + 2) begin
                fails++; $display("FAIL gap_latency: first valid cycle %0d want %0d", cb[0], wr_edge + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(0, 0);
        repeat (3) tick();
        fork
            for (int i = 0; i < 5; i++) begin din = W'(8 + i); dv = 1'b1; tick(); end
            begin rdy = 1'b1; repeat (3) tick(); rdy = 1'b0; end
        join
        dv = 1'b0;
        tests_run++;
        if (qb.size() != 3 || qb[0] !== W'(0) || qb[1] !== W'(4) || qb[2] !== W'(2) ||
            qn.size() != 3 || qn[2] !== W'(2)) begin
            fails++; $display("FAIL mid_preread: got n=%0d br2=%0d nat2=%0d want 3/2/2",
                              qb.size(), qb[2], qn[2]);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ifb.out_valid, ifb.out_last, ifn.out_valid, ifn.out_last, ovf_b, ovf_n} !== 6'b0 ||
            ifb.out_data !== '0 || ifn.out_data !== '0 || dc_b !== 16'd0) begin
            fails++; $display("FAIL mid_async_reset: got valid=%b/%b data=%h/%h dropped=%0d want all 0",
                              ifb.out_valid, ifn.out_valid, ifb.out_data, ifn.out_data, dc_b);
        end
        tick();
        rst_n = 1'b1;
        clear_mon();
        rdy = 1'b1;
        send(200, 0);
        repeat (16) tick();
        tests_run++;
        if (qb.size() != N || qn.size() != N) begin
            fails++; $display("FAIL mid_fresh_count: got %0d/%0d want 8/8", qb.size(), qn.size());
        end else begin
            for (int i = 0; i < N; i++) begin
                tests_run++;
                if (qb[i] !== W'(200 + BR8[i]) || qn[i] !== W'(200 + i) || ln[i] !== (i == 7)) begin
                    fails++; $display("FAIL mid_fresh[%0d]: got %0d/%0d want %0d/%0d",
                                      i, qb[i], qn[i], 200 + BR8[i], 200 + i);
                end
            end
        end
        tests_run++;
        if (dc_b !== 16'd0 || dc_n !== 16'd0) begin
            fails++; $display("FAIL mid_dropped: got %0d/%0d want 0/0", dc_b, dc_n);
        end
    endtask

    initial begin
        din = '0; dv = 1'b0; rdy = 1'b0;
        clear_mon();
        test_reset();
        test_single_frame();
        test_continuous();
        test_overflow();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
